// File: rtl/mix_columns_seq_pkg.sv
// mix_columns_seq_pkg
// Shared definitions for the column-serial MixColumns stage: state and
// column geometry, the FSM state enum, and the GF(2^8) helpers used by the
// column transform.
package mix_columns_seq_pkg;

  localparam int STATE_W  = 128;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; every MixColumns/InvMixColumns
  // coefficient (01,02,03,09,0b,0d,0e) fits in 4 bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Circulant coefficient k of the first matrix row; row r uses the first
  // row rotated right by r, so a_j is scaled by mix_coef(inv, j - r).
  function automatic logic [3:0] mix_coef(input logic inv, input logic [1:0] k);
    case (k)
      2'd0:    return inv ? 4'he : 4'h2;
      2'd1:    return inv ? 4'hb : 4'h3;
      2'd2:    return inv ? 4'hd : 4'h1;
      default: return inv ? 4'h9 : 4'h1;
    endcase
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if
// Upstream/downstream valid-ready bundle of the MixColumns stage.
//   in_*      : block from shift_rows (state, bypass, inverse select)
//   out_*     : result towards the round-key adder
//   busy      : stage holds a block (CALC or DONE)
// slave modport is the stage itself, master is the surrounding datapath.
interface mix_columns_seq_if;
  import mix_columns_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [0:STATE_W-1] in_state;
  logic               in_bypass;
  logic               in_inv;
  logic               out_valid;
  logic               out_ready;
  logic [0:STATE_W-1] out_state;
  logic               busy;

  modport slave (
    input  in_valid, in_state, in_bypass, in_inv, out_ready,
    output in_ready, out_valid, out_state, busy
  );

  modport master (
    output in_valid, in_state, in_bypass, in_inv, out_ready,
    input  in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_seq_mix_column.sv
// aes_mix_column
// Purely combinational transform of one 32-bit state column.
//   col_in  : a0..a3, a0 in the top byte
//   inv     : 1 = InvMixColumns, 0 = MixColumns
//   col_out : transformed column, same byte order
module aes_mix_column
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  input  logic             inv,
  output logic [COL_W-1:0] col_out
);

  always_comb begin
    col_out = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      for (int j = 0; j < NUM_COLS; j++) begin
        col_out[COL_W-1-BYTE_W*r -: BYTE_W] = col_out[COL_W-1-BYTE_W*r -: BYTE_W]
          ^ gf_mul(col_in[COL_W-1-BYTE_W*j -: BYTE_W], mix_coef(inv, 2'(j - r)));
      end
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Column-serial MixColumns/InvMixColumns stage between shift_rows and the
// round-key adder. A captured block is transformed COLS_PER_CYCLE columns
// per clock in place in the working register, then presented until taken.
// Bypass blocks (final round) go straight to the output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake/data bundle (slave side)
//   COLS_PER_CYCLE : 1, 2 or 4 columns per clock
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mix_columns_seq_if.slave    bus
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_e             state_q, state_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [0:STATE_W-1] work_q, work_d;
  logic               inv_q, inv_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               accept;

  logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];

  // Columns col_idx..col_idx+N-1 of the working register feed the
  // transform lanes; col_idx is always a multiple of N so it never
  // runs past column 3.
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_in[g] = work_q[COL_W*(int'(col_idx_q) + g) +: COL_W];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_mix_column u_col (
      .col_in  (col_in[g]),
      .inv     (inv_q),
      .col_out (col_out[g])
    );
  end

  // DONE with out_ready frees the slot in the same edge, hence the
  // combinational out_ready -> in_ready path.
  assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = work_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    inv_d     = inv_q;

    if (accept) begin
      work_d    = bus.in_state;
      inv_d     = bus.in_inv;
      col_idx_d = '0;
      state_d   = bus.in_bypass ? ST_DONE : ST_CALC;
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      state_d = ST_IDLE;
    end

    if (state_q == ST_CALC) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        work_d[COL_W*(int'(col_idx_q) + g) +: COL_W] = col_out[g];
      end
      if (col_idx_q == LAST_IDX) begin
        col_idx_d = '0;
        state_d   = ST_DONE;
      end else begin
        col_idx_d = col_idx_q + 2'(COLS_PER_CYCLE);
      end
    end

    // Status outputs are registered from the next state.
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_idx_q   <= '0;
      work_q      <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Column-serial AES MixColumns/InvMixColumns stage that consumes the 128-bit state produced by the shift_rows stage and produces the pre-AddRoundKey state of the round. A valid/ready handshake on both sides lets it sit between shift_rows and the round-key adder in the iterative round datapath. A per-block bypass serves the final round, which omits MixColumns.

## Interface
- COLS_PER_CYCLE, 1: columns transformed per clock; legal values 1, 2, 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream block present.
- in_ready  out  1  stage can accept a block this cycle.
- in_state  in  [0:127]  state from shift_rows; byte i = in_state[8i:8i+7], byte 0 at bit 0 (MSB).
- in_bypass  in  1  final round: pass state through unchanged.
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_state  out  [0:127]  result, same byte ordering.
- busy  out  1  high in CALC or DONE.

## Operation
- Column c = bytes 4c..4c+3; row r of column c = byte 4c+r (FIPS-197 column-major).
- Forward: r0'=2a0^3a1^a2^a3, r1'=a0^2a1^3a2^a3, r2'=a0^a1^2a2^3a3, r3'=3a0^a1^a2^2a3.
- Inverse: coefficients rotate 0e,0b,0d,09 in the same circulant pattern.
- GF(2^8) multiply by xtime: {b[6:0],0} ^ (b[7] ? 8'h1b : 0); all products 8-bit, sums XOR.
- FSM states IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid: capture in_state, in_bypass, in_inv into working regs; bypass → DONE, else → CALC with col_idx=0.
  - CALC: each cycle replace columns col_idx..col_idx+N-1 in the working reg; col_idx += N; on the last group → DONE. in_ready=0.
  - DONE: out_valid=1, out_state = working reg, held stable until out_ready. On out_ready: → IDLE, or, if in_valid also high, accept the new block in the same edge (→ CALC or DONE per its bypass).
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational out_ready→in_ready path is allowed.
- in_state/in_bypass/in_inv are sampled only at the accepting edge; later changes are ignored.
- in_valid may drop without acceptance; no block is recorded.

## Timing
- Reset (async assert, sync-released by the system): state=IDLE, col_idx=0, working reg=0, out_valid=0, out_state=128'h0, busy=0, in_ready=1 once rst_n high.
- Reset mid-CALC or mid-DONE: block discarded, no out_valid afterwards.
- Bypass latency: out_valid high in the cycle after the accepting edge.
- Transform latency: out_valid high 4/N cycles after the bypass case (N=1: 5th cycle after accept edge counting it as 1).
- Throughput: back-to-back with out_ready held high, one block every 4/N+1 cycles (bypass every cycle).
- col_idx wraps to 0 on entering DONE; never indexes past column 3.
- out_ready low in DONE: out_state and out_valid held indefinitely, no new accept.

## Structure
- Shared aes_pkg: STATE_W=128, BYTE_W=8, NUM_COLS=4, xtime and gf_mul helper functions, FSM state enum.
- One sub-module aes_mix_column: pure combinational 32-bit column transform with inv select; instantiated COLS_PER_CYCLE times.
- Top holds FSM, col_idx counter, working register, handshake logic.

## Test plan
- FIPS-197 App. B round 1, inv=0, bypass=0: in d4bf5d30e0b452aeb84111f11e2798e5 → out 046681e5e0cb199a48f8d37a2806264c after 4/N cycles.
- Inverse: in 046681e5e0cb199a48f8d37a2806264c, inv=1 → out d4bf5d30e0b452aeb84111f11e2798e5.
- Column vectors: db135345 f20a225c 01010101 c6c6c6c6 → 8e4da1bc 9fdc589d 01010101 c6c6c6c6.
- Bypass with in 3e175076b61c04678dfc2295f6a8bfc0 → same value, out_valid next cycle; then back-to-back bypass blocks each cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_state stable, in_ready=0; release with in_valid high → next block accepted same edge.
- Assert rst_n=0 during CALC of a block → outputs zero immediately, no out_valid after release; repeat all scenarios for COLS_PER_CYCLE=1,2,4.
